// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous-read imem and
// re-aligns the returned word with its PC and a valid bit for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [31:0]        i_redirect_pc,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic               o_imem_stall,
  input  logic [31:0]        i_imem_data,
  output logic [31:0]        o_instr,
  output logic [31:0]        o_pc,
  output logic               o_valid
);

  logic [31:0] fetch_pc_r;
  logic [31:0] resp_pc_r;
  logic        resp_valid_r;

  logic [31:0] fetch_pc_nxt_s;
  logic [31:0] resp_pc_nxt_s;
  logic        resp_valid_nxt_s;
  logic [31:0] redirect_target_s;

  assign redirect_target_s = i_redirect_pc & 32'hFFFF_FFFC;

  // Next-state selection: redirect beats stall, stall beats normal advance.
  always_comb begin
    fetch_pc_nxt_s   = fetch_pc_r;
    resp_pc_nxt_s    = resp_pc_r;
    resp_valid_nxt_s = resp_valid_r;
    if (i_redirect) begin
      // The word now being fetched belongs to the old path: drop it.
      fetch_pc_nxt_s   = redirect_target_s;
      resp_pc_nxt_s    = fetch_pc_r;
      resp_valid_nxt_s = 1'b0;
    end else if (i_stall) begin
      fetch_pc_nxt_s   = fetch_pc_r;
      resp_pc_nxt_s    = resp_pc_r;
      resp_valid_nxt_s = resp_valid_r;
    end else begin
      fetch_pc_nxt_s   = fetch_pc_r + 32'd4;
      resp_pc_nxt_s    = fetch_pc_r;
      resp_valid_nxt_s = 1'b1;
    end
  end

  // PC and response-tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r   <= RESET_PC;
      resp_pc_r    <= RESET_PC;
      resp_valid_r <= 1'b0;
    end else begin
      fetch_pc_r   <= fetch_pc_nxt_s;
      resp_pc_r    <= resp_pc_nxt_s;
      resp_valid_r <= resp_valid_nxt_s;
    end
  end

  // Output drive; imem data already carries its one-cycle latency.
  always_comb begin
    o_imem_addr  = fetch_pc_r[IMEM_AW+1:2];
    o_imem_stall = i_stall & ~i_redirect;
    o_instr      = i_imem_data;
    o_pc         = resp_pc_r;
    o_valid      = resp_valid_r;
  end

  fetch_stage_checker u_checker (
    .clk          (clk),
    .rst          (rst),
    .i_stall      (i_stall),
    .i_redirect   (i_redirect),
    .o_imem_stall (o_imem_stall),
    .o_pc         (o_pc),
    .o_valid      (o_valid)
  );

endmodule

// Structural invariants of the fetch stage outputs.
module fetch_stage_checker (
  input logic        clk,
  input logic        rst,
  input logic        i_stall,
  input logic        i_redirect,
  input logic        o_imem_stall,
  input logic [31:0] o_pc,
  input logic        o_valid
);

  a_stall_release: assert property (@(posedge clk) disable iff (rst)
    o_imem_stall == (i_stall && !i_redirect));

  a_pc_aligned: assert property (@(posedge clk) disable iff (rst)
    o_valid |-> (o_pc[1:0] == 2'b00));

  a_redirect_bubble: assert property (@(posedge clk) disable iff (rst)
    i_redirect |=> !o_valid);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: imem model, behavioural reference,
// directed scenarios and a randomized stall/redirect phase.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [7:0]  o_imem_addr;
  logic        o_imem_stall;
  logic [31:0] i_imem_data;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .IMEM_AW(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_addr   (o_imem_addr),
    .o_imem_stall  (o_imem_stall),
    .i_imem_data   (i_imem_data),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_valid       (o_valid)
  );

  // imem: word n holds 0x1000_0000 + n, address registered unless stalled.
  logic [7:0] mem_addr_q;
  always @(posedge clk) begin
    if (!o_imem_stall) mem_addr_q <= o_imem_addr;
  end
  assign i_imem_data = 32'h1000_0000 + {24'h0, mem_addr_q};

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) & 32'h0000_00FF);
  endfunction

  // Reference: next PC to fetch and the (pc, live) pair decode should see.
  logic [31:0] m_next = RESET_PC;
  logic [31:0] m_pc   = RESET_PC;
  logic        m_live = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_next <= RESET_PC;
      m_pc   <= RESET_PC;
      m_live <= 1'b0;
    end else if (i_redirect) begin
      m_live <= 1'b0;
      m_next <= {i_redirect_pc[31:2], 2'b00};
    end else if (!i_stall) begin
      m_pc   <= m_next;
      m_live <= 1'b1;
      m_next <= m_next + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare against the reference, away from the rising edge.
  always @(negedge clk) begin
    chk("valid", {31'd0, o_valid}, {31'd0, m_live});
    chk("imem_addr", {24'd0, o_imem_addr}, {24'd0, m_next[9:2]});
    chk("imem_stall", {31'd0, o_imem_stall}, {31'd0, i_stall & ~i_redirect});
    if (m_live) begin
      chk("pc", o_pc, m_pc);
      chk("instr", o_instr, word_at(m_pc));
    end
  end

  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    #1;
    i_stall       = st;
    i_redirect    = rd;
    i_redirect_pc = rpc;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_stall = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0;
    @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_addr", {24'd0, o_imem_addr}, 32'd0);
    chk("rst_istall", {31'd0, o_imem_stall}, 32'd0);
    #1 rst = 1'b0;
    #1 chk("cycle0_valid", {31'd0, o_valid}, 32'd0);

    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("start_pc", o_pc, 32'(4 * k));
      chk("start_instr", o_instr, 32'h1000_0000 + 32'(k));
      chk("start_valid", {31'd0, o_valid}, 32'd1);
    end

    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("stall_istall", {31'd0, o_imem_stall}, 32'd1);
      chk("stall_pc", o_pc, 32'h8);
      chk("stall_instr", o_instr, 32'h1000_0002);
      chk("stall_valid", {31'd0, o_valid}, 32'd1);
    end
    step(1'b0, 1'b0, 32'h0);
    chk("after_stall_pc", o_pc, 32'hC);
    chk("after_stall_instr", o_instr, 32'h1000_0003);

    step(1'b0, 1'b1, 32'h40);
    chk("redir_bubble", {31'd0, o_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("redir_pc", o_pc, 32'h40);
    chk("redir_instr", o_instr, 32'h1000_0010);
    step(1'b0, 1'b0, 32'h0);
    chk("redir_pc_next", o_pc, 32'h44);

    step(1'b1, 1'b1, 32'h83);
    chk("sr_istall", {31'd0, o_imem_stall}, 32'd0);
    chk("sr_bubble", {31'd0, o_valid}, 32'd0);
    chk("sr_addr", {24'd0, o_imem_addr}, 32'h20);
    step(1'b0, 1'b0, 32'h0);
    chk("sr_pc", o_pc, 32'h80);
    chk("sr_instr", o_instr, 32'h1000_0020);

    step(1'b0, 1'b1, 32'h3FC);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_pc", o_pc, 32'h3FC);
    chk("wrap_instr", o_instr, 32'h1000_00FF);
    chk("wrap_addr", {24'd0, o_imem_addr}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_pc2", o_pc, 32'h400);
    chk("wrap_instr2", o_instr, 32'h1000_0000);

    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    chk("top_pc", o_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    chk("top_wrap_pc", o_pc, 32'h0);
    chk("top_wrap_instr", o_instr, 32'h1000_0000);

    step(1'b0, 1'b1, 32'h100);
    step(1'b0, 1'b1, 32'h200);
    chk("b2b_bubble", {31'd0, o_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("b2b_pc", o_pc, 32'h200);
    chk("b2b_instr", o_instr, 32'h1000_0080);

    step(1'b0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1 chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_pc", o_pc, RESET_PC);
    chk("arst_addr", {24'd0, o_imem_addr}, 32'd0);
    #4 rst = 1'b0;
    @(negedge clk);
    chk("arst_cycle0", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    chk("arst_restart_pc", o_pc, RESET_PC);
    chk("arst_restart_valid", {31'd0, o_valid}, 32'd1);
    chk("arst_restart_instr", o_instr, 32'h1000_0000);

    for (int i = 0; i < 1500; i++) begin
      logic        st;
      logic        rd;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 25);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + ($urandom & 32'hF)) : $urandom;
      step(st, rd, rpc);
    end
    step(1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
